event_packetizer: RTL and testbench
===================================

// Module: event_packetizer
// PURPOSE
//  Downstream consumer of the 16-group pixel hierarchy. Watches the granted group (4x4 one-hot)
//  and the in-group pixel grant/address, timestamp and polarity it forwards. Forms the absolute
//  16x16 pixel address and packs one AER event word per new grant into a show-ahead FIFO.
//  Drains the FIFO over a valid/ready stream to the readout/serializer stage.
// PARAMETERS
//  TS_W        32  timestamp width in bits
//  FIFO_DEPTH  8   event FIFO depth in entries; power of 2, >= 2
//  DATA_W      TS_W+9  event word width = {polarity, y[3:0], x[3:0], timestamp}; derived, do not override
// PORTS
//  clk          in   1         system clock, rising edge
//  rst_n        in   1         asynchronous active-low reset
//  gnt_o        in   [3:0][3:0] group grant, one-hot, [grp_row][grp_col]
//  in_gnt_o     in   [3:0][3:0] pixel grant inside the granted group, one-hot
//  in_x_add     in   2         column of the granted pixel within its group
//  in_y_add     in   2         row of the granted pixel within its group
//  timestamp_in in   TS_W      timestamp of the granted pixel
//  polarity_in  in   1         polarity of the granted pixel
//  evt_valid    out  1         FIFO head valid
//  evt_ready    in   1         consumer accepts the head word
//  evt_data     out  DATA_W    FIFO head event word
//  fifo_level   out  $clog2(FIFO_DEPTH)+1  current occupancy
//  overflow     out  1         sticky: an event was dropped because the FIFO was full
//  grant_err    out  1         sticky: more than one gnt_o bit seen in one cycle
//  clr_flags    in   1         synchronous clear of overflow, grant_err and drop_cnt
//  drop_cnt     out  16        dropped-event count; see CONFIGURATION
// BEHAVIOUR
//  - Reset values: all outputs 0; FIFO empty; edge-detect register idle.
//  - hit = |gnt_o && |in_gnt_o.
//  - Group encode: gidx = index of lowest set gnt_o bit (row*4+col).
//    Absolute address: x = {gidx[1:0], in_x_add}; y = {gidx[3:2], in_y_add}.
//  - New event: hit && (prev cycle !hit || {gidx,x,y} != registered previous tag).
//    A held grant generates exactly one event.
//  - Push: a new event in cycle N is written at the end-of-N edge.
//    If the FIFO was empty, evt_valid=1 and evt_data=word from cycle N+1.
//  - Pop: evt_valid && evt_ready at an edge. evt_data shows the next entry the following cycle.
//  - Full FIFO with a new event and no pop: drop the event; overflow <= 1.
//    FIFO contents are unchanged.
//  - Full FIFO with a new event and a pop in the same cycle: both occur; level unchanged, no drop.
//  - Empty FIFO: a pop is impossible (evt_valid=0); level never underflows.
//  - Pointers carry an extra wrap bit; full = equal index with wrap bits differing.
//  - gnt_o with popcount > 1: grant_err <= 1. Event is still formed from the lowest index.
//  - clr_flags and a set condition in the same cycle: the set wins.
//  - evt_data is stable while evt_valid && !evt_ready.
//  - Reset asserted mid-operation: FIFO emptied immediately and queued events lost.
//    Outputs return to reset values asynchronously.
// CONFIGURATION
//  `EVT_DROP_CNT_EN defined: drop_cnt increments on every dropped event.
//    It saturates at 16'hFFFF and is cleared by clr_flags.
//  `EVT_DROP_CNT_EN undefined: no counter logic is built; drop_cnt is tied to 16'h0.
//    overflow still operates.
// STRUCTURE
//  - Package evt_pkg: GRID_DIM=16, GRP_DIM=4 and GRP_CNT=16 constants.
//    evt_word_t packed struct {polarity, y, x, ts}; onehot16_to_idx function.
//  - Sub-module evt_fifo: parameterized synchronous show-ahead FIFO
//    (push/pop/full/empty/level), async active-low reset.
//    event_packetizer instantiates it once.
// TESTING
//  1. gnt_o[1][2]=1, in_gnt_o[3][1]=1, x=1, y=3, ts=32'h1234, pol=1, held 5 cycles, evt_ready=1
//     -> exactly one word: x=4'd9, y=4'd7, pol=1, ts=32'h1234.
//  2. 8 distinct events with evt_ready=0, then a 9th -> fifo_level=8, overflow=1.
//     Drain yields the first 8 in order; drop_cnt=1 with macro, 0 without.
//  3. FIFO full, new event and evt_ready=1 in the same cycle -> no drop, level stays 8.
//     The new word is last out.
//  4. gnt_o[0][0] and gnt_o[2][3] set together -> grant_err=1.
//     Event uses group 0 (x=in_x_add, y=in_y_add); clr_flags pulse clears grant_err.
//  5. 3 events queued, rst_n low mid-stream -> evt_valid=0 and level=0 immediately.
//     After release, no stale words appear.

Source files
------------

// File: rtl/evt_pkg.sv
// -----------------------------------------------------------------------------
// evt_pkg
// Shared constants, the AER event word layout and small encode helpers for
// the event packetizer slice.
//   GRID_DIM  : pixels per side of the full array (16)
//   GRP_DIM   : groups per side of the array (4)
//   GRP_CNT   : number of groups (16)
//   EVT_TS_W  : timestamp width of the reference event word (32)
//   evt_word_t: {polarity, y[3:0], x[3:0], ts}
// -----------------------------------------------------------------------------
package evt_pkg;

    localparam int GRID_DIM = 16;
    localparam int GRP_DIM  = 4;
    localparam int GRP_CNT  = 16;
    localparam int EVT_TS_W = 32;

    typedef struct packed {
        logic                polarity;
        logic [3:0]          y;
        logic [3:0]          x;
        logic [EVT_TS_W-1:0] ts;
    } evt_word_t;

    // Index of the lowest set bit; 0 when no bit is set.
    function automatic logic [3:0] onehot16_to_idx(input logic [GRP_CNT-1:0] vec);
        logic [3:0] idx;
        idx = 4'd0;
        // Scan downwards so the lowest set bit is the last one written.
        for (int i = GRP_CNT - 1; i >= 0; i--) begin
            if (vec[i]) begin
                idx = 4'(i);
            end else begin
                idx = idx;
            end
        end
        return idx;
    endfunction

    // True when more than one bit of the vector is set.
    function automatic logic multi_hot16(input logic [GRP_CNT-1:0] vec);
        return (vec & (vec - 16'd1)) != 16'd0;
    endfunction

endpackage

// File: rtl/evt_fifo.sv
// -----------------------------------------------------------------------------
// evt_fifo
// Synchronous show-ahead FIFO: the head entry is always visible on rd_data.
// A push into a full FIFO is accepted only when a pop happens in the same
// cycle. A pop on an empty FIFO is ignored.
// Ports:
//   clk, rst_n : clock (rising edge), asynchronous active-low reset
//   push       : write wr_data at the end of this cycle
//   wr_data    : word to write
//   pop        : retire the head entry at the end of this cycle
//   rd_data    : current head entry (valid when !empty)
//   full/empty : occupancy flags
//   level      : current number of stored entries
// -----------------------------------------------------------------------------
module evt_fifo #(
    parameter  int WIDTH = 41,
    parameter  int DEPTH = 8,
    localparam int AW    = $clog2(DEPTH)
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             push,
    input  logic [WIDTH-1:0] wr_data,
    input  logic             pop,
    output logic [WIDTH-1:0] rd_data,
    output logic             full,
    output logic             empty,
    output logic [AW:0]      level
);

    // Pointers carry one extra wrap bit above the index bits.
    logic [AW:0]      wr_ptr_r;
    logic [AW:0]      rd_ptr_r;
    logic [WIDTH-1:0] mem_r [DEPTH];
    logic             push_ok_s;
    logic             pop_ok_s;

    // Occupancy flags, accepted-operation qualifiers and head read-out.
    always_comb begin
        empty     = (wr_ptr_r == rd_ptr_r);
        full      = (wr_ptr_r[AW-1:0] == rd_ptr_r[AW-1:0]) && (wr_ptr_r[AW] != rd_ptr_r[AW]);
        level     = wr_ptr_r - rd_ptr_r;
        pop_ok_s  = pop && !empty;
        push_ok_s = push && (!full || pop_ok_s);
        rd_data   = mem_r[rd_ptr_r[AW-1:0]];
    end

    // Pointer update.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr_r <= '0;
            rd_ptr_r <= '0;
        end else begin
            if (push_ok_s) begin
                wr_ptr_r <= wr_ptr_r + (AW+1)'(1);
            end
            if (pop_ok_s) begin
                rd_ptr_r <= rd_ptr_r + (AW+1)'(1);
            end
        end
    end

    // Storage; cleared on reset so no stale word is ever presented.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < DEPTH; i++) begin
                mem_r[i] <= '0;
            end
        end else if (push_ok_s) begin
            mem_r[wr_ptr_r[AW-1:0]] <= wr_data;
        end
    end

endmodule

// File: rtl/event_packetizer.sv
// -----------------------------------------------------------------------------
// event_packetizer
// Turns each new pixel grant from the 16-group hierarchy into one AER event
// word {polarity, y, x, timestamp}, queues it in a show-ahead FIFO and drains
// it over a valid/ready stream.
// Build option: define EVT_DROP_CNT_EN to build the saturating drop counter;
// otherwise drop_cnt is tied to zero.
// Ports:
//   clk, rst_n      : clock (rising edge), asynchronous active-low reset
//   gnt_o           : group grant, one-hot, [grp_row][grp_col]
//   in_gnt_o        : pixel grant inside the granted group
//   in_x_add/in_y_add : pixel column/row inside the group
//   timestamp_in, polarity_in : attributes of the granted pixel
//   evt_valid/evt_ready/evt_data : output event stream (FIFO head)
//   fifo_level      : FIFO occupancy
//   overflow        : sticky, event dropped on a full FIFO
//   grant_err       : sticky, more than one group granted in a cycle
//   clr_flags       : synchronous clear of overflow, grant_err, drop_cnt
//   drop_cnt        : dropped-event count (zero when the counter is not built)
// -----------------------------------------------------------------------------
module event_packetizer
    import evt_pkg::*;
#(
    parameter  int TS_W       = 32,
    parameter  int FIFO_DEPTH = 8,
    localparam int DATA_W     = TS_W + 9,
    localparam int LVL_W      = $clog2(FIFO_DEPTH) + 1
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic [3:0][3:0]   gnt_o,
    input  logic [3:0][3:0]   in_gnt_o,
    input  logic [1:0]        in_x_add,
    input  logic [1:0]        in_y_add,
    input  logic [TS_W-1:0]   timestamp_in,
    input  logic              polarity_in,
    output logic              evt_valid,
    input  logic              evt_ready,
    output logic [DATA_W-1:0] evt_data,
    output logic [LVL_W-1:0]  fifo_level,
    output logic              overflow,
    output logic              grant_err,
    input  logic              clr_flags,
    output logic [15:0]       drop_cnt
);

    logic [GRP_CNT-1:0] gnt_flat_s;
    logic               hit_s;
    logic [3:0]         gidx_s;
    logic [3:0]         x_s;
    logic [3:0]         y_s;
    logic [11:0]        tag_s;
    logic               new_evt_s;
    logic               multi_s;
    logic [DATA_W-1:0]  word_s;
    logic               pop_s;
    logic               drop_s;
    logic               fifo_full_s;
    logic               fifo_empty_s;

    logic               prev_hit_r;
    logic [11:0]        prev_tag_r;
    logic               overflow_r;
    logic               grant_err_r;

    // Address formation, new-event detection and drop decision.
    always_comb begin
        gnt_flat_s = gnt_o;
        hit_s      = (|gnt_flat_s) && (|in_gnt_o);
        gidx_s     = onehot16_to_idx(gnt_flat_s);
        x_s        = {gidx_s[1:0], in_x_add};
        y_s        = {gidx_s[3:2], in_y_add};
        tag_s      = {gidx_s, x_s, y_s};
        // A held grant matches the stored tag and so produces a single event.
        new_evt_s  = hit_s && (!prev_hit_r || (tag_s != prev_tag_r));
        multi_s    = multi_hot16(gnt_flat_s);
        word_s     = {polarity_in, y_s, x_s, timestamp_in};
        evt_valid  = !fifo_empty_s;
        pop_s      = evt_valid && evt_ready;
        // A simultaneous pop frees the slot, so only an unpopped full FIFO drops.
        drop_s     = new_evt_s && fifo_full_s && !pop_s;
        overflow   = overflow_r;
        grant_err  = grant_err_r;
    end

    // Previous-cycle grant state for edge detection.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            prev_hit_r <= 1'b0;
            prev_tag_r <= 12'd0;
        end else begin
            prev_hit_r <= hit_s;
            prev_tag_r <= tag_s;
        end
    end

    // Sticky status flags; a set condition overrides a same-cycle clear.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            overflow_r  <= 1'b0;
            grant_err_r <= 1'b0;
        end else begin
            overflow_r  <= drop_s  ? 1'b1 : (clr_flags ? 1'b0 : overflow_r);
            grant_err_r <= multi_s ? 1'b1 : (clr_flags ? 1'b0 : grant_err_r);
        end
    end

`ifdef EVT_DROP_CNT_EN
    logic [15:0] drop_cnt_r;

    // Saturating drop counter; a drop in a clearing cycle restarts it at one.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            drop_cnt_r <= 16'd0;
        end else if (drop_s) begin
            drop_cnt_r <= clr_flags ? 16'd1 :
                          ((drop_cnt_r == 16'hFFFF) ? drop_cnt_r : drop_cnt_r + 16'd1);
        end else if (clr_flags) begin
            drop_cnt_r <= 16'd0;
        end
    end

    assign drop_cnt = drop_cnt_r;
`else
    assign drop_cnt = 16'h0;
`endif

    evt_fifo #(
        .WIDTH (DATA_W),
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clk     (clk),
        .rst_n   (rst_n),
        .push    (new_evt_s),
        .wr_data (word_s),
        .pop     (pop_s),
        .rd_data (evt_data),
        .full    (fifo_full_s),
        .empty   (fifo_empty_s),
        .level   (fifo_level)
    );

endmodule

// File: tb/tb_event_packetizer.sv
// -----------------------------------------------------------------------------
// tb_event_packetizer
// Self-checking bench for event_packetizer: a queue-based reference model of
// the event stream plus directed scenarios with literal expectations.
// -----------------------------------------------------------------------------
module tb_event_packetizer;
    import evt_pkg::*;

    localparam int TS_W       = 32;
    localparam int FIFO_DEPTH = 8;
    localparam int DATA_W     = TS_W + 9;
    localparam int LVL_W      = $clog2(FIFO_DEPTH) + 1;
`ifdef EVT_DROP_CNT_EN
    localparam logic [15:0] EXP_DROP1 = 16'd1;
`else
    localparam logic [15:0] EXP_DROP1 = 16'd0;
`endif

    logic              clk = 1'b0;
    logic              rst_n = 1'b0;
    logic [3:0][3:0]   gnt_o = '0;
    logic [3:0][3:0]   in_gnt_o = '0;
    logic [1:0]        in_x_add = 2'd0;
    logic [1:0]        in_y_add = 2'd0;
    logic [TS_W-1:0]   timestamp_in = '0;
    logic              polarity_in = 1'b0;
    logic              evt_valid;
    logic              evt_ready = 1'b0;
    logic [DATA_W-1:0] evt_data;
    logic [LVL_W-1:0]  fifo_level;
    logic              overflow;
    logic              grant_err;
    logic              clr_flags = 1'b0;
    logic [15:0]       drop_cnt;

    int n_checks = 0;
    int n_fail   = 0;
    int pops     = 0;
    logic [DATA_W-1:0] last_data = '0;

    // Reference model state
    logic [DATA_W-1:0] m_q[$];
    logic              m_ovf = 1'b0;
    logic              m_ge = 1'b0;
    logic [15:0]       m_dcnt = 16'd0;
    logic              m_prev_hit = 1'b0;
    int                m_px = 0;
    int                m_py = 0;

    event_packetizer #(.TS_W(TS_W), .FIFO_DEPTH(FIFO_DEPTH)) dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .gnt_o        (gnt_o),
        .in_gnt_o     (in_gnt_o),
        .in_x_add     (in_x_add),
        .in_y_add     (in_y_add),
        .timestamp_in (timestamp_in),
        .polarity_in  (polarity_in),
        .evt_valid    (evt_valid),
        .evt_ready    (evt_ready),
        .evt_data     (evt_data),
        .fifo_level   (fifo_level),
        .overflow     (overflow),
        .grant_err    (grant_err),
        .clr_flags    (clr_flags),
        .drop_cnt     (drop_cnt)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    function automatic logic [DATA_W-1:0] mk_word(input int ex, input int ey,
                                                  input logic [TS_W-1:0] ts, input logic pol);
        evt_word_t w;
        w.polarity = pol;
        w.y        = 4'(ey);
        w.x        = 4'(ex);
        w.ts       = ts;
        return w;
    endfunction

    // Model: at every edge, apply the stream rules to the queue of words.
    task automatic model_loop();
        logic [15:0] g;
        logic        hit;
        logic        is_new;
        logic        pop;
        logic        set_ovf;
        logic        set_ge;
        int          gi;
        int          ex;
        int          ey;
        forever begin
            @(posedge clk or negedge rst_n);
            if (!rst_n) begin
                m_q.delete();
                m_ovf      = 1'b0;
                m_ge       = 1'b0;
                m_dcnt     = 16'd0;
                m_prev_hit = 1'b0;
            end else begin
                g   = gnt_o;
                hit = (g != 16'd0) && (in_gnt_o != 16'd0);
                gi  = 0;
                for (int i = 15; i >= 0; i--) if (g[i]) gi = i;
                ex  = (gi % 4) * 4 + int'(in_x_add);
                ey  = (gi / 4) * 4 + int'(in_y_add);
                is_new  = hit && (!m_prev_hit || ex != m_px || ey != m_py);
                pop     = (m_q.size() > 0) && evt_ready;
                set_ovf = 1'b0;
                set_ge  = ($countones(g) > 1);
                if (pop) void'(m_q.pop_front());
                if (is_new) begin
                    if (m_q.size() < FIFO_DEPTH) m_q.push_back(mk_word(ex, ey, timestamp_in, polarity_in));
                    else set_ovf = 1'b1;
                end
`ifdef EVT_DROP_CNT_EN
                if (set_ovf) m_dcnt = clr_flags ? 16'd1 : ((m_dcnt == 16'hFFFF) ? m_dcnt : m_dcnt + 16'd1);
                else if (clr_flags) m_dcnt = 16'd0;
`endif
                m_ovf = set_ovf ? 1'b1 : (clr_flags ? 1'b0 : m_ovf);
                m_ge  = set_ge  ? 1'b1 : (clr_flags ? 1'b0 : m_ge);
                m_prev_hit = hit;
                m_px = ex;
                m_py = ey;
            end
        end
    endtask

    // Compare: every falling edge, DUT outputs against the model.
    task automatic compare_loop();
        forever begin
            @(negedge clk);
            if (rst_n) begin
                check("valid", 64'(evt_valid), 64'(m_q.size() > 0));
                if (m_q.size() > 0) check("data", 64'(evt_data), 64'(m_q[0]));
                check("level", 64'(fifo_level), 64'(m_q.size()));
                check("overflow", 64'(overflow), 64'(m_ovf));
                check("grant_err", 64'(grant_err), 64'(m_ge));
                check("drop_cnt", 64'(drop_cnt), 64'(m_dcnt));
                if (evt_valid && evt_ready) begin
                    pops++;
                    last_data = evt_data;
                end
            end
        end
    endtask

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    task automatic set_evt(input int row, input int col, input int px, input int py,
                           input logic [TS_W-1:0] ts, input logic pol);
        gnt_o    = '0;
        gnt_o[row][col] = 1'b1;
        in_gnt_o = '0;
        in_gnt_o[py][px] = 1'b1;
        in_x_add = 2'(px);
        in_y_add = 2'(py);
        timestamp_in = ts;
        polarity_in  = pol;
    endtask

    task automatic idle();
        gnt_o    = '0;
        in_gnt_o = '0;
    endtask

    initial begin
        fork
            model_loop();
            compare_loop();
        join_none

        #1;
        check("rst_valid", 64'(evt_valid), 64'd0);
        check("rst_level", 64'(fifo_level), 64'd0);
        check("rst_flags", 64'({overflow, grant_err}), 64'd0);
        check("rst_drop", 64'(drop_cnt), 64'd0);
        cyc();
        cyc();
        rst_n = 1'b1;
        cyc();

        // 1: held grant produces exactly one event
        pops = 0;
        evt_ready = 1'b1;
        set_evt(1, 2, 1, 3, 32'h1234, 1'b1);
        cyc();
        check("t1_valid", 64'(evt_valid), 64'd1);
        check("t1_word", 64'(evt_data), 64'({1'b1, 4'd7, 4'd9, 32'h1234}));
        repeat (4) cyc();
        idle();
        repeat (3) cyc();
        check("t1_pops", 64'(pops), 64'd1);

        // 2: eight queued, ninth dropped
        evt_ready = 1'b0;
        for (int i = 0; i < 9; i++) begin
            set_evt(i / 4, i % 4, i % 4, (i + 1) % 4, 32'h100 + 32'(i), 1'(i));
            cyc();
        end
        idle();
        check("t2_level", 64'(fifo_level), 64'd8);
        check("t2_overflow", 64'(overflow), 64'd1);
        check("t2_drop", 64'(drop_cnt), 64'(EXP_DROP1));
        cyc();

        // 3: full FIFO, push and pop together
        pops = 0;
        set_evt(3, 0, 3, 3, 32'h300, 1'b1);
        evt_ready = 1'b1;
        cyc();
        check("t3_level", 64'(fifo_level), 64'd8);
        check("t3_drop", 64'(drop_cnt), 64'(EXP_DROP1));
        idle();
        repeat (10) cyc();
        check("t3_pops", 64'(pops), 64'd9);
        check("t3_last", 64'(last_data), 64'({1'b1, 4'd15, 4'd3, 32'h300}));

        // 4: two groups granted at once
        gnt_o    = '0;
        gnt_o[0][0] = 1'b1;
        gnt_o[2][3] = 1'b1;
        in_gnt_o = '0;
        in_gnt_o[1][2] = 1'b1;
        in_x_add = 2'd2;
        in_y_add = 2'd1;
        timestamp_in = 32'h44;
        polarity_in  = 1'b0;
        cyc();
        check("t4_gerr", 64'(grant_err), 64'd1);
        check("t4_word", 64'(evt_data), 64'({1'b0, 4'd1, 4'd2, 32'h44}));
        idle();
        clr_flags = 1'b1;
        cyc();
        clr_flags = 1'b0;
        check("t4_gerr_clr", 64'(grant_err), 64'd0);
        check("t4_ovf_clr", 64'(overflow), 64'd0);
        check("t4_drop_clr", 64'(drop_cnt), 64'd0);
        cyc();

        // 5: reset mid-stream discards queued words
        evt_ready = 1'b0;
        for (int i = 0; i < 3; i++) begin
            set_evt(i / 4, i % 4, i % 4, (i + 1) % 4, 32'h500 + 32'(i), 1'b0);
            cyc();
        end
        idle();
        cyc();
        check("t5_level", 64'(fifo_level), 64'd3);
        #2;
        rst_n = 1'b0;
        #1;
        check("t5_rst_valid", 64'(evt_valid), 64'd0);
        check("t5_rst_level", 64'(fifo_level), 64'd0);
        cyc();
        cyc();
        rst_n = 1'b1;
        evt_ready = 1'b1;
        pops = 0;
        repeat (4) cyc();
        check("t5_no_stale", 64'(evt_valid), 64'd0);
        check("t5_pops", 64'(pops), 64'd0);

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

endmodule
